// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the execute stage.
// Single-cycle ops (add/sub/logic/shift/compare) finish in one cycle;
// MUL/MULHU use a WIDTH-step shift-add multiplier. DIVU/REMU use a
// WIDTH-step restoring divider, present only when ALU_MC_DIV_EN is
// defined; otherwise their opcodes decode as illegal.
// One operation in flight; valid/ready handshakes on both sides.
module alu_mc #(
   parameter int WIDTH    = 32,
   parameter int OP_WIDTH = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [OP_WIDTH-1:0] opcode,
   input  logic [WIDTH-1:0]    a,
   input  logic [WIDTH-1:0]    b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    result,
   output logic                zero,
   output logic                illegal
);

   localparam int SHAMT_W = $clog2(WIDTH);

   localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(5'b00001);
   localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(5'b10001);
   localparam logic [OP_WIDTH-1:0] OP_XOR   = OP_WIDTH'(5'b01001);
   localparam logic [OP_WIDTH-1:0] OP_OR    = OP_WIDTH'(5'b01101);
   localparam logic [OP_WIDTH-1:0] OP_AND   = OP_WIDTH'(5'b01111);
   localparam logic [OP_WIDTH-1:0] OP_SLL   = OP_WIDTH'(5'b00011);
   localparam logic [OP_WIDTH-1:0] OP_SRL   = OP_WIDTH'(5'b00101);
   localparam logic [OP_WIDTH-1:0] OP_SRA   = OP_WIDTH'(5'b10101);
   localparam logic [OP_WIDTH-1:0] OP_SLT   = OP_WIDTH'(5'b00111);
   localparam logic [OP_WIDTH-1:0] OP_SLTU  = OP_WIDTH'(5'b01011);
   localparam logic [OP_WIDTH-1:0] OP_MUL   = OP_WIDTH'(5'b11001);
   localparam logic [OP_WIDTH-1:0] OP_MULHU = OP_WIDTH'(5'b11011);
`ifdef ALU_MC_DIV_EN
   localparam logic [OP_WIDTH-1:0] OP_DIVU  = OP_WIDTH'(5'b11101);
   localparam logic [OP_WIDTH-1:0] OP_REMU  = OP_WIDTH'(5'b11111);
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
`ifdef ALU_MC_DIV_EN
      , S_DIV = 2'd3
`endif
   } state_t;

   state_t               state, state_nxt;
   logic [WIDTH-1:0]     a_q;
`ifdef ALU_MC_DIV_EN
   logic [WIDTH-1:0]     b_q;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH:0]       div_diff;
   logic                 div_ge;
   logic [2*WIDTH-1:0]   div_next;
`endif
   // Shared accumulator: {hi, lo} = product while multiplying,
   // {remainder, quotient/dividend} while dividing.
   logic [2*WIDTH-1:0]   acc;
   logic [SHAMT_W-1:0]   cnt;
   logic                 sel_hi;
   logic                 last;

   logic [SHAMT_W-1:0]   shamt;
   logic [WIDTH-1:0]     dec_res;
   logic                 dec_ill;
   logic                 dec_mul;
   logic                 dec_div;
   logic                 dec_hi;

   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;

   assign shamt = b[SHAMT_W-1:0];
   assign last  = (cnt == SHAMT_W'(WIDTH-1));

   // Decode the incoming opcode and compute single-cycle results
   always_comb begin
      dec_res = '0;
      dec_ill = 1'b0;
      dec_mul = 1'b0;
      dec_div = 1'b0;
      dec_hi  = 1'b0;
      case (opcode)
         OP_ADD:   dec_res = a + b;
         OP_SUB:   dec_res = a - b;
         OP_XOR:   dec_res = a ^ b;
         OP_OR:    dec_res = a | b;
         OP_AND:   dec_res = a & b;
         OP_SLL:   dec_res = a << shamt;
         OP_SRL:   dec_res = a >> shamt;
         OP_SRA:   dec_res = WIDTH'($signed(a) >>> shamt);
         OP_SLT:   dec_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU:  dec_res = {{(WIDTH-1){1'b0}}, a < b};
         OP_MUL:   dec_mul = 1'b1;
         OP_MULHU: begin
            dec_mul = 1'b1;
            dec_hi  = 1'b1;
         end
`ifdef ALU_MC_DIV_EN
         // A zero divisor is resolved at accept: no iterations needed
         OP_DIVU: begin
            if (b == '0) dec_res = '1;
            else         dec_div = 1'b1;
         end
         OP_REMU: begin
            dec_hi = 1'b1;
            if (b == '0) dec_res = a;
            else         dec_div = 1'b1;
         end
`endif
         default:  dec_ill = 1'b1;
      endcase
   end

   // One shift-add step: add multiplicand into the high half on lsb, shift right
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
      mul_next = {mul_sum, acc[WIDTH-1:1]};
   end

`ifdef ALU_MC_DIV_EN
   // One restoring-division step: trial-subtract divisor from shifted remainder
   always_comb begin
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff  = div_shift - {1'b0, b_q};
      div_ge    = ~div_diff[WIDTH];
      div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                   acc[WIDTH-2:0], div_ge};
   end
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (in_valid) begin
               if (dec_mul)      state_nxt = S_MUL;
`ifdef ALU_MC_DIV_EN
               else if (dec_div) state_nxt = S_DIV;
`endif
               else              state_nxt = S_DONE;
            end
         end
         S_MUL:  if (last) state_nxt = S_DONE;
`ifdef ALU_MC_DIV_EN
         S_DIV:  if (last) state_nxt = S_DONE;
`endif
         S_DONE: if (out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Handshake outputs
   always_comb begin
      in_ready  = (state == S_IDLE);
      out_valid = (state == S_DONE);
   end

   // Datapath: latch operands, iterate, register the final result
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q     <= '0;
`ifdef ALU_MC_DIV_EN
         b_q     <= '0;
`endif
         acc     <= '0;
         cnt     <= '0;
         sel_hi  <= 1'b0;
         result  <= '0;
         zero    <= 1'b0;
         illegal <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
`ifdef ALU_MC_DIV_EN
                  b_q     <= b;
                  acc     <= dec_div ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
`else
                  acc     <= {{WIDTH{1'b0}}, b};
`endif
                  cnt     <= '0;
                  sel_hi  <= dec_hi;
                  result  <= dec_res;
                  zero    <= (dec_res == '0);
                  illegal <= dec_ill;
               end
            end
            S_MUL: begin
               acc <= mul_next;
               cnt <= cnt + SHAMT_W'(1);
               if (last) begin
                  result  <= sel_hi ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
                  zero    <= (sel_hi ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0]) == '0;
                  illegal <= 1'b0;
               end
            end
`ifdef ALU_MC_DIV_EN
            S_DIV: begin
               acc <= div_next;
               cnt <= cnt + SHAMT_W'(1);
               if (last) begin
                  result  <= sel_hi ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0];
                  zero    <= (sel_hi ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0]) == '0;
                  illegal <= 1'b0;
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Directed testbench for alu_mc (WIDTH=32). Divider tests follow ALU_MC_DIV_EN.
module tb_alu_mc;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  opcode;
   logic [31:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   int tests = 0;
   int fails = 0;

   alu_mc #(.WIDTH(32), .OP_WIDTH(5)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Issue one op, wait for completion, take the result; lat = -1 on timeout
   task automatic run_op(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] r, output logic z, output logic il,
                         output int lat, output logic rdy_busy);
      int w = 0;
      @(negedge clk);
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      in_valid = 1'b1; opcode = op; a = av; b = bv;
      @(posedge clk);
      #1;
      // Garbage on the inputs while busy must not disturb the operation
      in_valid = 1'b0; opcode = 5'b00001; a = 32'h0; b = 32'h0;
      lat = 0; rdy_busy = 1'b0;
      forever begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
         if (in_ready) rdy_busy = 1'b1;
         if (lat > 100) begin
            lat = -1;
            break;
         end
      end
      r = result; z = zero; il = illegal;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      opcode = 5'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0 ||
          zero !== 1'b0 || illegal !== 1'b0) begin
         fails++;
         $display("FAIL reset: out_valid=%b in_ready=%b result=%h zero=%b illegal=%b, want 0 1 00000000 0 0",
                  out_valid, in_ready, result, zero, illegal);
      end
   endtask

   task automatic test_single();
      logic [4:0]  ops [10] = '{5'b00001, 5'b10001, 5'b00001, 5'b10101, 5'b00101,
                                5'b00111, 5'b01011, 5'b01001, 5'b01111, 5'b00011};
      logic [31:0] av  [10] = '{32'haa554422, 32'hff009867, 32'h00ffdd88, 32'h80000000, 32'h80000000,
                                32'hffffffff, 32'hffffffff, 32'hf0f0f0f0, 32'hf0f0f0f0, 32'h00000001};
      logic [31:0] bv  [10] = '{32'h00993300, 32'h984487dd, 32'hff009865, 32'h00000024, 32'h00000024,
                                32'h00000001, 32'h00000001, 32'hf0f0f0f0, 32'h0ff00ff0, 32'h0000003f};
      logic [31:0] ex  [10] = '{32'haaee7722, 32'h66bc108a, 32'h000075ed, 32'hf8000000, 32'h08000000,
                                32'h00000001, 32'h00000000, 32'h00000000, 32'h00f000f0, 32'h80000000};
      logic [31:0] r;
      logic z, il, rb;
      int lat;
      for (int i = 0; i < 10; i++) begin
         run_op(ops[i], av[i], bv[i], r, z, il, lat, rb);
         tests++;
         if (r !== ex[i] || z !== (ex[i] == 32'h0) || il !== 1'b0 || lat != 1) begin
            fails++;
            $display("FAIL single[%0d] op=%b: result=%h zero=%b illegal=%b lat=%0d, want %h %b 0 1",
                     i, ops[i], r, z, il, lat, ex[i], ex[i] == 32'h0);
         end
      end
   endtask

   task automatic test_mul();
      logic [31:0] r;
      logic z, il, rb;
      int lat;
      run_op(5'b11001, 32'h00001234, 32'h00005678, r, z, il, lat, rb);
      tests++;
      if (r !== 32'h06260060 || z !== 1'b0 || il !== 1'b0 || lat != 33 || rb !== 1'b0) begin
         fails++;
         $display("FAIL mul: result=%h zero=%b illegal=%b lat=%0d rdy_busy=%b, want 06260060 0 0 33 0",
                  r, z, il, lat, rb);
      end
      run_op(5'b11011, 32'hffffffff, 32'hffffffff, r, z, il, lat, rb);
      tests++;
      if (r !== 32'hfffffffe || lat != 33 || rb !== 1'b0) begin
         fails++;
         $display("FAIL mulhu: result=%h lat=%0d rdy_busy=%b, want fffffffe 33 0", r, lat, rb);
      end
      run_op(5'b11001, 32'h00010000, 32'h00010000, r, z, il, lat, rb);
      tests++;
      if (r !== 32'h0 || z !== 1'b1 || lat != 33) begin
         fails++;
         $display("FAIL mul_wrap: result=%h zero=%b lat=%0d, want 00000000 1 33", r, z, lat);
      end
   endtask

   task automatic test_div();
      logic [31:0] r;
      logic z, il, rb;
      int lat;
`ifdef ALU_MC_DIV_EN
      run_op(5'b11101, 32'd100, 32'd7, r, z, il, lat, rb);
      tests++;
      if (r !== 32'h0000000e || il !== 1'b0 || lat != 33 || rb !== 1'b0) begin
         fails++;
         $display("FAIL divu: result=%h illegal=%b lat=%0d, want 0000000e 0 33", r, il, lat);
      end
      run_op(5'b11111, 32'd100, 32'd7, r, z, il, lat, rb);
      tests++;
      if (r !== 32'h00000002 || lat != 33) begin
         fails++;
         $display("FAIL remu: result=%h lat=%0d, want 00000002 33", r, lat);
      end
      run_op(5'b11101, 32'h00001234, 32'h0, r, z, il, lat, rb);
      tests++;
      if (r !== 32'hffffffff || il !== 1'b0 || lat != 1) begin
         fails++;
         $display("FAIL divu_by0: result=%h illegal=%b lat=%0d, want ffffffff 0 1", r, il, lat);
      end
      run_op(5'b11111, 32'h00001234, 32'h0, r, z, il, lat, rb);
      tests++;
      if (r !== 32'h00001234 || lat != 1) begin
         fails++;
         $display("FAIL remu_by0: result=%h lat=%0d, want 00001234 1", r, lat);
      end
      run_op(5'b11101, 32'hffffffff, 32'h00000010, r, z, il, lat, rb);
      tests++;
      if (r !== 32'h0fffffff || lat != 33) begin
         fails++;
         $display("FAIL divu_big: result=%h lat=%0d, want 0fffffff 33", r, lat);
      end
`else
      run_op(5'b11101, 32'd100, 32'd7, r, z, il, lat, rb);
      tests++;
      if (r !== 32'h0 || z !== 1'b1 || il !== 1'b1 || lat != 1) begin
         fails++;
         $display("FAIL divu_nodiv: result=%h zero=%b illegal=%b lat=%0d, want 00000000 1 1 1", r, z, il, lat);
      end
      run_op(5'b11111, 32'd100, 32'd7, r, z, il, lat, rb);
      tests++;
      if (r !== 32'h0 || il !== 1'b1 || lat != 1) begin
         fails++;
         $display("FAIL remu_nodiv: result=%h illegal=%b lat=%0d, want 00000000 1 1", r, il, lat);
      end
`endif
   endtask

   task automatic test_illegal();
      logic [31:0] r;
      logic z, il, rb;
      int lat;
      run_op(5'b00000, 32'h12345678, 32'h9abcdef0, r, z, il, lat, rb);
      tests++;
      if (r !== 32'h0 || z !== 1'b1 || il !== 1'b1 || lat != 1) begin
         fails++;
         $display("FAIL illegal: result=%h zero=%b illegal=%b lat=%0d, want 00000000 1 1 1", r, z, il, lat);
      end
      // A legal op afterwards must clear the illegal flag
      run_op(5'b01101, 32'h0000f000, 32'h0000000f, r, z, il, lat, rb);
      tests++;
      if (r !== 32'h0000f00f || il !== 1'b0 || z !== 1'b0) begin
         fails++;
         $display("FAIL illegal_clear: result=%h illegal=%b zero=%b, want 0000f00f 0 0", r, il, z);
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      in_valid = 1'b1; opcode = 5'b00001; a = 32'h00000005; b = 32'h00000003;
      @(posedge clk);
      #1 in_valid = 1'b0; a = 32'hdeadbeef;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         tests++;
         if (out_valid !== 1'b1 || result !== 32'h00000008 || zero !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL hold[%0d]: out_valid=%b result=%h zero=%b in_ready=%b, want 1 00000008 0 0",
                     i, out_valid, result, zero, in_ready);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r;
      logic z, il, rb;
      int lat;
      @(negedge clk);
      in_valid = 1'b1; opcode = 5'b11001; a = 32'h00000003; b = 32'h00000007;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      #1;
      tests++;
      if (out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b0 || illegal !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: out_valid=%b result=%h zero=%b illegal=%b, want 0 00000000 0 0",
                  out_valid, result, zero, illegal);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_idle: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
      run_op(5'b00001, 32'h00000010, 32'h00000020, r, z, il, lat, rb);
      tests++;
      if (r !== 32'h00000030 || il !== 1'b0 || lat != 1) begin
         fails++;
         $display("FAIL reset_mid_add: result=%h illegal=%b lat=%0d, want 00000030 0 1", r, il, lat);
      end
      // A fresh multiply after the abandoned one must start from clean state
      run_op(5'b11001, 32'h00000003, 32'h00000007, r, z, il, lat, rb);
      tests++;
      if (r !== 32'h00000015 || lat != 33) begin
         fails++;
         $display("FAIL reset_mid_mul: result=%h lat=%0d, want 00000015 33", r, lat);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_mul();
      test_div();
      test_illegal();
      test_backpressure();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
